// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-port round-robin single-port SRAM arbiter with optional zero-fill after reset
module sram_arbiter #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 512,
  parameter bit CLEAR_ON_RESET = 1'b1,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST,

  input  logic             p0_valid,
  input  logic [AW-1:0]    p0_addr,
  output logic             p0_ready,
  output logic             p0_rvalid,
  output logic [WIDTH-1:0] p0_rdata,

  input  logic             p1_valid,
  input  logic [AW-1:0]    p1_addr,
  input  logic             p1_we,
  input  logic [WIDTH-1:0] p1_wmask,
  input  logic [WIDTH-1:0] p1_wdata,
  output logic             p1_ready,
  output logic             p1_rvalid,
  output logic [WIDTH-1:0] p1_rdata,

  output logic             sram_cen,
  output logic             sram_gwen,
  output logic [WIDTH-1:0] sram_wen,
  output logic [AW-1:0]    sram_a,
  output logic [WIDTH-1:0] sram_d,
  input  logic [WIDTH-1:0] sram_q
);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] clear_cnt;
  logic          rr;
  logic          p0_pend;
  logic          p1_pend;
  logic          run;
  logic          grant0;
  logic          grant1;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= CLEAR_ON_RESET ? S_CLEAR : S_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == S_CLEAR && clear_cnt == LAST_ADDR) begin
      state_nxt = S_RUN;
    end
  end

  // rr always ends up favouring the port that did not win, whether or not both competed
  always_ff @(posedge CLK) begin
    if (RST) begin
      clear_cnt <= '0;
      rr        <= 1'b0;
      p0_pend   <= 1'b0;
      p1_pend   <= 1'b0;
    end else begin
      if (state == S_CLEAR) begin
        clear_cnt <= clear_cnt + AW'(1);
      end
      if (grant0) begin
        rr <= 1'b1;
      end else if (grant1) begin
        rr <= 1'b0;
      end
      p0_pend <= grant0;
      p1_pend <= grant1 && !p1_we;
    end
  end

  // Ready looks only at the other port's valid so a requester may hold valid on ready
  always_comb begin
    run       = (state == S_RUN) && !RST;
    p0_ready  = run && (!p1_valid || !rr);
    p1_ready  = run && (!p0_valid || rr);
    grant0    = p0_valid && p0_ready;
    grant1    = p1_valid && p1_ready;

    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = '1;
    sram_a    = '0;
    sram_d    = '0;
    if (!RST && state == S_CLEAR) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = '0;
      sram_a    = clear_cnt;
    end else if (grant0 || grant1) begin
      sram_cen  = 1'b0;
      sram_a    = grant1 ? p1_addr : p0_addr;
      sram_gwen = ~(grant1 && p1_we);
      sram_wen  = ~p1_wmask;
      sram_d    = p1_wdata;
    end

    p0_rvalid = p0_pend && !RST;
    p1_rvalid = p1_pend && !RST;
    p0_rdata  = p0_rvalid ? sram_q : '0;
    p1_rdata  = p1_rvalid ? sram_q : '0;
  end

endmodule
